// File: rtl/morse_keyer.sv
// -----------------------------------------------------------------------------
// morse_keyer
//   Transmit side of the Morse path. Takes one encoded letter through a
//   valid/ready handshake and plays it out as a timed on/off key waveform.
//   Dot = 1 unit on, dash = 3 units on, gap between elements = 1 unit off,
//   gap after the letter = 3 units off (7 units when the word gap is in use).
//   All timing comes from one unit counter that is cleared on every state
//   entry, so each period is an exact multiple of UNIT_CYCLES.
//
// Parameters
//   UNIT_CYCLES  clk cycles per Morse time unit (>= 2)
//   MAX_LEN      max elements per letter (width of sym_bits_i, <= 7)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sym_valid_i  letter presented on sym_bits_i / sym_len_i
//   sym_ready_o  keyer can accept a letter (idle only)
//   sym_bits_i   element pattern, bit 0 sent first; 1 = dash, 0 = dot
//   sym_len_i    element count 0..MAX_LEN (larger values saturate)
//   word_end_i   letter ends a word (only with MORSE_WORD_GAP_EN)
//   key_out_o    registered key output, 1 = tone / LED on
//   busy_o       letter in progress (inverse of sym_ready_o)
//
// Build option
//   MORSE_WORD_GAP_EN  adds word_end_i; a letter latched with word_end_i = 1
//                      is followed by a 7-unit word space instead of 3 units.
// -----------------------------------------------------------------------------
module morse_keyer #(
    parameter int unsigned UNIT_CYCLES = 50_000_000 / 20,
    parameter int unsigned MAX_LEN     = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sym_valid_i,
    output logic               sym_ready_o,
    input  logic [MAX_LEN-1:0] sym_bits_i,
    input  logic [2:0]         sym_len_i,
`ifdef MORSE_WORD_GAP_EN
    input  logic               word_end_i,
`endif
    output logic               key_out_o,
    output logic               busy_o
);

    localparam int unsigned     CntW    = $clog2(UNIT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(UNIT_CYCLES - 1);
    localparam logic [2:0]      LenMax  = 3'(MAX_LEN);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMark = 2'd1,
        StEgap = 2'd2,
        StLgap = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;       // cycles within the current unit
    logic [2:0]           units_q, units_d;   // whole units elapsed in this state
    logic [MAX_LEN-1:0]   bits_q, bits_d;     // remaining elements, current in bit 0
    logic [2:0]           rem_q, rem_d;       // elements left, including current
    logic                 word_q, word_d;
    logic                 key_q, key_d;

    logic                 transfer;
    logic                 unit_tick;
    logic [2:0]           units_last;
    logic                 period_done;
    logic [2:0]           len_sat;
    logic                 word_in;

    // -------------------------------------------------------------------------
    // Handshake and input conditioning
    // -------------------------------------------------------------------------
    assign sym_ready_o = (state_q == StIdle);
    assign busy_o      = ~sym_ready_o;
    assign key_out_o   = key_q;
    assign transfer    = sym_valid_i & sym_ready_o;
    assign len_sat     = (sym_len_i > LenMax) ? LenMax : sym_len_i;

`ifdef MORSE_WORD_GAP_EN
    assign word_in = word_end_i;
`else
    assign word_in = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Period length of the current state, expressed as last unit index
    // -------------------------------------------------------------------------
    always_comb begin
        units_last = 3'd0;
        unique case (state_q)
            StMark:  units_last = bits_q[0] ? 3'd2 : 3'd0;
            StEgap:  units_last = 3'd0;
            StLgap:  units_last = word_q ? 3'd6 : 3'd2;
            default: units_last = 3'd0;
        endcase
    end

    assign unit_tick   = (cnt_q == CntLast);
    assign period_done = unit_tick && (units_q == units_last);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        rem_d   = rem_q;
        word_d  = word_q;

        unique case (state_q)
            StIdle: begin
                if (transfer) begin
                    bits_d  = sym_bits_i;
                    rem_d   = len_sat;
                    word_d  = word_in;
                    state_d = (len_sat != 3'd0) ? StMark : StLgap;
                end
            end
            StMark: begin
                if (period_done) begin
                    bits_d  = bits_q >> 1;
                    rem_d   = rem_q - 3'd1;
                    state_d = (rem_q > 3'd1) ? StEgap : StLgap;
                end
            end
            StEgap: begin
                if (period_done) begin
                    state_d = StMark;
                end
            end
            StLgap: begin
                if (period_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Every transition changes state, so a state change marks a fresh period.
    always_comb begin
        cnt_d   = cnt_q;
        units_d = units_q;
        if ((state_d != state_q) || (state_q == StIdle)) begin
            cnt_d   = '0;
            units_d = 3'd0;
        end else if (unit_tick) begin
            cnt_d   = '0;
            units_d = units_q + 3'd1;
        end else begin
            cnt_d   = cnt_q + CntW'(1);
        end
    end

    // Registered key: follows the state being entered so it lines up with it.
    assign key_d = (state_d == StMark);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            units_q <= 3'd0;
            bits_q  <= '0;
            rem_q   <= 3'd0;
            word_q  <= 1'b0;
            key_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            units_q <= units_d;
            bits_q  <= bits_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            key_q   <= key_d;
        end
    end

endmodule
